// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - frames COUNT adder results into a wide total; optional ACC_SATURATE_EN clamps instead of wrapping
module adder_result_accumulator #(
  parameter int WIDTH     = 4,
  parameter int COUNT     = 16,
  parameter int ACC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 cout_in,
  input  logic                 in_valid,
  input  logic                 start,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CNT_W = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

  // Reject configurations the datapath cannot represent.
  generate
    if (ACC_WIDTH < WIDTH + 1) begin : g_bad_acc_width
      $error("ACC_WIDTH must be at least WIDTH+1");
    end
    if (COUNT < 1) begin : g_bad_count
      $error("COUNT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [ACC_WIDTH-1:0] acc, acc_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 sticky, sticky_n;
  logic [ACC_WIDTH-1:0] acc_out_n;
  logic                 overflow_n;

  logic [ACC_WIDTH-1:0] sample;
  logic [ACC_WIDTH:0]   add_wide;
  logic                 carry;
  logic [ACC_WIDTH-1:0] add_res;

  // Zero-extended sample and the one-bit-wider add whose MSB is the overflow carry.
  always_comb begin
    sample   = ACC_WIDTH'({cout_in, sum_in});
    add_wide = {1'b0, acc} + {1'b0, sample};
    carry    = add_wide[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
    add_res  = carry ? {ACC_WIDTH{1'b1}} : add_wide[ACC_WIDTH-1:0];
`else
    add_res  = add_wide[ACC_WIDTH-1:0];
`endif
  end

  // Next-state and datapath updates; start takes priority over everything but reset.
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    cnt_n      = cnt;
    sticky_n   = sticky;
    acc_out_n  = acc_out;
    overflow_n = overflow;
    if (start) begin
      sticky_n = 1'b0;
      if (in_valid) begin
        // The sample riding on start is the first of the new frame.
        acc_n = sample;
        cnt_n = CNT_W'(1);
        if (COUNT == 1) begin
          // A single sample always fits, so a one-sample frame never overflows.
          acc_out_n  = sample;
          overflow_n = 1'b0;
          state_n    = DONE;
        end else begin
          state_n = ACC;
        end
      end else begin
        acc_n   = '0;
        cnt_n   = '0;
        state_n = ACC;
      end
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            acc_n    = add_res;
            sticky_n = sticky | carry;
            cnt_n    = cnt + CNT_W'(1);
            if (cnt == CNT_W'(COUNT - 1)) begin
              acc_out_n  = add_res;
              overflow_n = sticky | carry;
              state_n    = DONE;
            end
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = state;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      sticky   <= sticky_n;
      acc_out  <= acc_out_n;
      overflow <= overflow_n;
    end
  end

  // Status outputs decode straight from the state register, so they are glitch-free.
  always_comb begin
    out_valid = (state == DONE);
    busy      = (state == ACC);
  end

endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Downstream consumer of the parameterised adder. Takes each `{cout, sum}` result the adder produces, qualified by a valid strobe, and accumulates a frame of `COUNT` results into a wider register. At the end of the frame it presents the total with a one-cycle `out_valid` pulse and an overflow flag. A frame begins on a `start` pulse; results arriving outside a frame are discarded.

## Interface
- `WIDTH`, default 4: width of the adder's `sum`. Each sample is `WIDTH+1` bits (`cout` is the MSB).
- `COUNT`, default 16: number of samples per frame. Must be at least 1.
- `ACC_WIDTH`, default 8: width of the accumulator and of `acc_out`. Must be at least `WIDTH+1`; elaboration fails otherwise.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `sum_in` input, `WIDTH` bits: adder sum.
- `cout_in` input, 1 bit: adder carry out.
- `in_valid` input, 1 bit: `sum_in`/`cout_in` hold a result this cycle.
- `start` input, 1 bit: begin a new frame. Clears any frame in progress.
- `acc_out` output, `ACC_WIDTH` bits: total of the last completed frame.
- `out_valid` output, 1 bit: one-cycle pulse when `acc_out` updates.
- `overflow` output, 1 bit: the last completed frame exceeded `ACC_WIDTH` bits.
- `busy` output, 1 bit: a frame is in progress (state ACC).

## Operation
- FSM states:
  - IDLE to ACC on `start`.
  - ACC to DONE on accepting the `COUNT`-th sample.
  - DONE to IDLE unconditionally.
  - DONE to ACC if `start` is high.
  - ACC to ACC (restart) on `start`.
- Reset (`rst` high at an edge) sets: state IDLE, internal acc 0, sample counter 0, sticky overflow 0, `acc_out` 0, `out_valid` 0, `overflow` 0. `rst` overrides every other input.
- Sample value is `{cout_in, sum_in}`, zero-extended. The add is computed at `ACC_WIDTH+1` bits, and a set carry bit marks overflow.
- Overflow is sticky for the frame and cleared on `start`.
- Without saturation, the accumulator keeps the low `ACC_WIDTH` bits (wrap-around).
- A sample is accepted when `in_valid` is high in ACC, or in the same cycle as `start` from any state. A sample accepted with `start` becomes the first sample: acc is set to the sample and the counter to 1.
- `in_valid` in IDLE or DONE without `start` is ignored.
- Gaps (`in_valid` low) in ACC are allowed; acc and the counter hold.
- Completion: on the edge that accepts sample `COUNT`, `acc_out` is set to the final total and `overflow` to the sticky flag OR the carry of that add. State goes to DONE.
- `acc_out` and `overflow` hold until the next completion or reset.
- With `COUNT`=1, the `start`+`in_valid` cycle completes the frame directly.

## Timing
- `out_valid` is high for exactly the one cycle after the edge that accepts the last sample, i.e. the cycle the FSM is in DONE.
- Latency from last sample to `out_valid`/`acc_out`: 1 clock.
- `busy` is registered: high from the edge after `start` until the edge that accepts the last sample.
- `start` in DONE: `out_valid` stays high that cycle (the result is already registered), and the next frame begins at the same edge.
- Reset mid-frame: no `out_valid` is produced, and `acc_out` reads 0 on the following cycle.
- No back-pressure. The block accepts one sample per clock, matching the adder's pipelined output rate.

## Configuration
- `ACC_SATURATE_EN` defined: on an add carry, the accumulator clamps to all ones and stays there for the rest of the frame. `acc_out` shows the clamped value and `overflow` is set.
- `ACC_SATURATE_EN` undefined: the accumulator wraps modulo 2^`ACC_WIDTH` and `overflow` is set.
- The `overflow` flag behaves the same in both builds.

## Test plan
- Reset: hold `rst` for 2 cycles with `start`/`in_valid` toggling -> `acc_out`=0, `out_valid`=0, `overflow`=0, `busy`=0.
- Basic frame: `start` with `in_valid`, then 16 consecutive samples `{0,0011}` -> one `out_valid` pulse 1 cycle after the last sample, `acc_out`=48, `overflow`=0.
- Overflow: 16 samples `{1,1111}` (value 31, total 496) -> `acc_out`=240 and `overflow`=1 with wrap; `acc_out`=255 and `overflow`=1 with `ACC_SATURATE_EN`.
- Gaps and idle discard:
  - Drive 3 samples of 7 in IDLE (must be ignored).
  - Then run a frame of 16 samples of 2, with `in_valid` low every other cycle.
  - Expect `acc_out`=32, `busy` high throughout the frame, and a single `out_valid`.
- Restart: 5 samples of 10, then `start`+`in_valid` with a sample of 1, then 15 more samples of 1 -> `acc_out`=16 and exactly one `out_valid`.
- Reset mid-frame: after 7 samples, pulse `rst` -> `busy`=0 and `acc_out`=0 next cycle, and no `out_valid` even if `in_valid` continues.
